// File: rtl/morse_char_sequencer.sv
// morse_char_sequencer
// Looks up one character in the external 16-entry Morse code table mux and
// plays it on the tone line as timed dots and dashes. The trailing
// inter-character gap is part of the character.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     request to send one character (honoured only when idle)
//   char_sel  character index, captured together with start
//   mux_sel   registered select to the code-table mux
//   mux_code  combinational code from the mux (1 = dash, 0 = dot, MSB first)
//   tone      registered key output, 1 during a mark
//   busy      high from LOAD through DONE
//   done      one-cycle pulse in the DONE cycle
module morse_char_sequencer #(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned CODE_W      = 5,
    parameter int unsigned SEL_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  char_sel,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic [CODE_W-1:0] mux_code,
    output logic              tone,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TIMER_W = $clog2(3 * UNIT_CYCLES + 1);
    localparam int unsigned CNT_W   = $clog2(CODE_W + 1);

    // Timer holds "cycles remaining minus one", so a state lasts load+1 cycles.
    localparam logic [TIMER_W-1:0] UNIT_LOAD  = TIMER_W'(UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TRIPLE_LOAD = TIMER_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MARK  = 3'd2,
        SPACE = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [CODE_W-1:0]  shreg, shreg_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [SEL_W-1:0]   mux_sel_next;
    logic               tone_next;
    logic               busy_next;
    logic               done_next;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            count   <= '0;
            timer   <= '0;
            mux_sel <= '0;
            tone    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            count   <= count_next;
            timer   <= timer_next;
            mux_sel <= mux_sel_next;
            tone    <= tone_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // Next-state and next-output logic; tone/done are computed for the state
    // being entered so the registered outputs line up with the state.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        count_next   = count;
        timer_next   = timer;
        mux_sel_next = mux_sel;
        tone_next    = 1'b0;
        busy_next    = busy;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = LOAD;
                    mux_sel_next = char_sel;
                    busy_next    = 1'b1;
                end
            end

            LOAD: begin
                // Only cycle in which mux_code is looked at.
                shreg_next = mux_code;
                count_next = CNT_W'(CODE_W);
                state_next = MARK;
                tone_next  = 1'b1;
                timer_next = mux_code[CODE_W-1] ? TRIPLE_LOAD : UNIT_LOAD;
            end

            MARK: begin
                tone_next = 1'b1;
                if (timer == '0) begin
                    shreg_next = shreg << 1;
                    count_next = count - CNT_W'(1);
                    tone_next  = 1'b0;
                    if (count_next != '0) begin
                        state_next = SPACE;
                        timer_next = UNIT_LOAD;
                    end else begin
                        state_next = GAP;
                        timer_next = TRIPLE_LOAD;
                    end
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end

            SPACE: begin
                if (timer == '0) begin
                    state_next = MARK;
                    tone_next  = 1'b1;
                    timer_next = shreg[CODE_W-1] ? TRIPLE_LOAD : UNIT_LOAD;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end

            GAP: begin
                if (timer == '0) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end

            DONE: begin
                // start is not looked at here; a held start retriggers from IDLE.
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Directed bench for morse_char_sequencer: one instance at UNIT_CYCLES=4 for
// the timing and abort cases, one at UNIT_CYCLES=1 for back-to-back retrigger.
module tb_morse_char_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A, UNIT_CYCLES = 4
    logic       rst, start;
    logic [3:0] char_sel, mux_sel;
    logic [4:0] mux_code;
    logic       tone, busy, done;

    // Instance B, UNIT_CYCLES = 1
    logic       rst1, start1;
    logic [3:0] char_sel1, mux_sel1;
    logic [4:0] mux_code1;
    logic       tone1, busy1, done1;

    morse_char_sequencer #(.UNIT_CYCLES(4), .CODE_W(5), .SEL_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .char_sel (char_sel),
        .mux_sel  (mux_sel),
        .mux_code (mux_code),
        .tone     (tone),
        .busy     (busy),
        .done     (done)
    );

    morse_char_sequencer #(.UNIT_CYCLES(1), .CODE_W(5), .SEL_W(4)) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .start    (start1),
        .char_sel (char_sel1),
        .mux_sel  (mux_sel1),
        .mux_code (mux_code1),
        .tone     (tone1),
        .busy     (busy1),
        .done     (done1)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Capture of one character on instance A
    bit          tone_q[$];
    bit          exp_q[$];
    int unsigned cap_busy, cap_done, cap_done_idx, mux_bad;
    bit          mid_code, mid_start;

    // Advance to #1 after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected tone per busy cycle for UNIT_CYCLES=4:
    // LOAD low, marks of 4/12, spaces of 4, gap of 12, DONE low.
    task automatic build_exp(input logic [4:0] code);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int e = 4; e >= 0; e--) begin
            repeat (code[e] ? 12 : 4) exp_q.push_back(1'b1);
            if (e != 0) repeat (4) exp_q.push_back(1'b0);
        end
        repeat (12) exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endtask

    // Issue start on instance A and record until busy drops (bounded).
    task automatic send(input logic [3:0] sel, input logic [4:0] code);
        char_sel = sel;
        mux_code = code;
        start    = 1'b1;
        step();
        start    = 1'b0;
        tone_q.delete();
        cap_busy = 0; cap_done = 0; cap_done_idx = 0; mux_bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            cap_busy++;
            tone_q.push_back(tone);
            if (done) begin
                cap_done++;
                cap_done_idx = i;
            end
            if (mux_sel != sel) mux_bad++;
            if (mid_code && i == 1) mux_code = ~code;
            if (mid_start) begin
                if (i >= 1 && i <= 3) begin
                    start    = 1'b1;
                    char_sel = 4'd3;
                end else begin
                    start = 1'b0;
                end
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [4:0] code, input int unsigned exp_busy);
        int unsigned mism;
        build_exp(code);
        check({tag, "_busy_cycles"}, cap_busy, exp_busy);
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= tone_q.size()) mism++;
            else if (tone_q[i] != exp_q[i]) mism++;
        end
        check({tag, "_tone_mismatches"}, mism, 0);
        check({tag, "_done_pulses"}, cap_done, 1);
        check({tag, "_done_index"}, cap_done_idx, exp_busy - 1);
        check({tag, "_mux_sel_bad_cycles"}, mux_bad, 0);
        check({tag, "_idle_after"}, {busy, done, tone}, 0);
    endtask

    logic [16:0] tone_v, busy_v, done_v;
    int unsigned done_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  start = 1'b0;  char_sel = 4'd0;  mux_code = 5'd0;
        rst1 = 1'b1; start1 = 1'b0; char_sel1 = 4'd0; mux_code1 = 5'd0;
        mid_code = 1'b0; mid_start = 1'b0;
        step();
        step();
        check("reset_a_outputs", {mux_sel, tone, busy, done}, 0);
        check("reset_b_outputs", {mux_sel1, tone1, busy1, done1}, 0);
        rst = 1'b0;
        rst1 = 1'b0;
        step();
        check("idle_holds", {mux_sel, tone, busy, done}, 0);

        // All dots: 1 + 5*4 + 4*4 + 12 + 1
        send(4'd5, 5'b00000);
        verify("t1_dots", 5'b00000, 50);
        check("t1_mux_sel_kept", mux_sel, 5);

        // All dashes: 1 + 5*12 + 4*4 + 12 + 1
        step();
        send(4'd7, 5'b11111);
        verify("t2_dashes", 5'b11111, 90);

        // Dot then four dashes, mux_code flipped right after LOAD
        step();
        mid_code = 1'b1;
        send(4'd2, 5'b01111);
        mid_code = 1'b0;
        verify("t3_mixed", 5'b01111, 82);

        // start/char_sel=3 during the first mark is ignored
        step();
        mid_start = 1'b1;
        send(4'd5, 5'b00000);
        mid_start = 1'b0;
        verify("t4_ignored_start", 5'b00000, 50);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done) done_seen++;
            step();
        end
        check("t4_no_second_char", done_seen, 0);

        // Reset during the third mark (busy index 17..20)
        char_sel = 4'd5;
        mux_code = 5'b00000;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int i = 0; i < 18; i++) step();
        check("t5_in_third_mark", {busy, tone}, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_abort_outputs", {mux_sel, tone, busy, done}, 0);
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done || busy || tone) done_seen++;
            step();
        end
        check("t5_quiet_after_abort", done_seen, 0);
        // 1 + (12+4+12+12+4) + 16 + 12 + 1
        send(4'd9, 5'b10110);
        verify("t5_after_reset", 5'b10110, 74);

        // UNIT_CYCLES=1, start held high: index 0 is LOAD, 13 DONE, 14 IDLE, 15 LOAD
        mux_code1 = 5'b00000;
        char_sel1 = 4'd6;
        start1    = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            tone_v[i] = tone1;
            busy_v[i] = busy1;
            done_v[i] = done1;
            step();
        end
        check("t6_tone_pattern", tone_v, 17'b1_000000_1010101010);
        check("t6_busy_pattern", busy_v, 17'b11_0_11111111111111);
        check("t6_done_pattern", done_v, 17'b000_1_0000000000000);
        check("t6_mux_sel", mux_sel1, 6);
        start1 = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done1) done_seen++;
            step();
        end
        check("t6_second_char_done", done_seen, 1);
        check("t6_idle_after", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
